// File: rtl/clkloss_mon.sv
// Clock-loss watchdog: samples a monitored clock as asynchronous data, declares it
// ALIVE after a run of timely rising edges and LOST when no edge arrives within TIMEOUT.
module clkloss_mon #(
    parameter int TIMEOUT = 16,
    parameter int LOCKCNT = 4,
    parameter int CNTW    = 8
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            MCLK,
    input  logic            CLR,
    output logic            ALIVE,
    output logic            LOST,
    output logic            LOSS_P,
    output logic [CNTW-1:0] PERIOD
);

    localparam int NW = $clog2(LOCKCNT + 1);
    localparam logic [CNTW-1:0] TMO    = CNTW'(TIMEOUT);
    localparam logic [CNTW-1:0] TMO_M1 = CNTW'(TIMEOUT - 1);
    localparam logic [NW-1:0]   LCK    = NW'(LOCKCNT);

    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_ACQ  = 2'd1,
        S_RUN  = 2'd2,
        S_LOSS = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            s1_q, s2_q, s3_q;
    logic [CNTW-1:0] t_q, t_d;
    logic [NW-1:0]   n_q, n_d;
    logic [CNTW-1:0] period_q, period_d;
    logic            alive_q, lost_q, lossp_q;
    logic            edge_e;
    logic            loss_entry;

    assign edge_e = s2_q & ~s3_q;

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        period_d = period_q;

        if (edge_e) begin
            t_d = '0;
        end else if (t_q != TMO) begin
            t_d = t_q + CNTW'(1);
        end else begin
            t_d = t_q;
        end

        // WAIT and LOSS have no reference edge, so only ACQ/RUN measure a period.
        case (state_q)
            S_WAIT, S_LOSS: begin
                if (edge_e) begin
                    if (LOCKCNT == 1) begin
                        state_d = S_RUN;
                    end else begin
                        state_d = S_ACQ;
                        n_d     = NW'(1);
                    end
                end
            end
            S_ACQ: begin
                if (edge_e) begin
                    period_d = t_q + CNTW'(1);
                    if (n_q + NW'(1) == LCK) begin
                        state_d = S_RUN;
                    end else begin
                        n_d = n_q + NW'(1);
                    end
                end else if (t_q == TMO_M1) begin
                    state_d = S_LOSS;
                end
            end
            S_RUN: begin
                if (edge_e) begin
                    period_d = t_q + CNTW'(1);
                end else if (t_q == TMO_M1) begin
                    state_d = S_LOSS;
                end
            end
            default: state_d = S_WAIT;
        endcase

        loss_entry = (state_q != S_LOSS) && (state_d == S_LOSS);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            s3_q     <= 1'b0;
            state_q  <= S_WAIT;
            t_q      <= '0;
            n_q      <= '0;
            period_q <= '0;
            alive_q  <= 1'b0;
            lost_q   <= 1'b0;
            lossp_q  <= 1'b0;
        end else begin
            s1_q     <= MCLK;
            s2_q     <= s1_q;
            s3_q     <= s2_q;
            state_q  <= state_d;
            t_q      <= t_d;
            n_q      <= n_d;
            period_q <= period_d;
            alive_q  <= (state_d == S_RUN);
            lossp_q  <= loss_entry;
            // A loss entry outranks a simultaneous clear.
            if (loss_entry) begin
                lost_q <= 1'b1;
            end else if (CLR) begin
                lost_q <= 1'b0;
            end
        end
    end

    assign ALIVE  = alive_q;
    assign LOST   = lost_q;
    assign LOSS_P = lossp_q;
    assign PERIOD = period_q;

endmodule

// File: tb/tb_clkloss_mon.sv
// Directed bench for clkloss_mon (TIMEOUT=16, LOCKCNT=4, CNTW=8) with hand-computed
// expectations; each MCLK rise is acted on at the third CLK edge after it is driven.
module tb_clkloss_mon;

    logic       CLK;
    logic       RST;
    logic       MCLK;
    logic       CLR;
    logic       ALIVE;
    logic       LOST;
    logic       LOSS_P;
    logic [7:0] PERIOD;

    int checks   = 0;
    int failures = 0;

    clkloss_mon #(.TIMEOUT(16), .LOCKCNT(4), .CNTW(8)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .MCLK  (MCLK),
        .CLR   (CLR),
        .ALIVE (ALIVE),
        .LOST  (LOST),
        .LOSS_P(LOSS_P),
        .PERIOD(PERIOD)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // One MCLK period of 8 CLK cycles; its edge is acted on at the 3rd tick.
    task automatic pulse8();
        MCLK = 1'b1;
        step(4);
        MCLK = 1'b0;
        step(4);
    endtask

    initial begin
        RST  = 1'b1;
        MCLK = 1'b0;
        CLR  = 1'b0;
        step(2);
        check("rst_alive",  ALIVE,  0);
        check("rst_lost",   LOST,   0);
        check("rst_lossp",  LOSS_P, 0);
        check("rst_period", PERIOD, 0);
        #3 RST = 1'b0;

        // WAIT: no timeout while MCLK is idle
        for (int i = 0; i < 100; i++) begin
            step(1);
            check("wait_lossp", LOSS_P, 0);
        end
        check("wait_alive",  ALIVE,  0);
        check("wait_lost",   LOST,   0);
        check("wait_period", PERIOD, 0);

        // Acquire at period 8
        pulse8();
        check("acq1_period", PERIOD, 0);
        pulse8();
        check("acq2_period", PERIOD, 8);
        pulse8();
        check("acq3_alive", ALIVE, 0);
        MCLK = 1'b1;
        step(2);
        check("acq4_pre_alive", ALIVE, 0);
        step(1);
        check("acq4_alive",  ALIVE,  1);
        check("acq4_period", PERIOD, 8);
        check("acq4_lost",   LOST,   0);
        step(1);
        MCLK = 1'b0;
        step(4);
        pulse8();
        pulse8();
        check("run_alive",  ALIVE,  1);
        check("run_period", PERIOD, 8);
        check("run_lost",   LOST,   0);

        // Stop MCLK: loss 16 edges after the last acted edge (5 already elapsed)
        step(10);
        check("stop15_alive", ALIVE,  1);
        check("stop15_lost",  LOST,   0);
        check("stop15_lossp", LOSS_P, 0);
        step(1);
        check("loss_alive", ALIVE,  0);
        check("loss_lost",  LOST,   1);
        check("loss_lossp", LOSS_P, 1);
        step(1);
        check("loss_lossp_drop", LOSS_P, 0);
        check("loss_lost_hold",  LOST,   1);

        // Re-acquire: LOST stays sticky, PERIOD not updated by the LOSS edge
        pulse8();
        check("reacq1_period", PERIOD, 8);
        pulse8();
        pulse8();
        check("reacq3_alive", ALIVE, 0);
        MCLK = 1'b1;
        step(3);
        check("reacq4_alive", ALIVE, 1);
        check("reacq4_lost",  LOST,  1);
        step(1);
        MCLK = 1'b0;
        step(4);
        CLR = 1'b1;
        step(1);
        CLR = 1'b0;
        check("clr_lost",  LOST,  0);
        check("clr_alive", ALIVE, 1);

        // Boundary: interval 9, then exactly 16 (no loss), then 17 (loss)
        MCLK = 1'b1;
        step(3);
        check("int9_period", PERIOD, 9);
        step(5);
        MCLK = 1'b0;
        step(8);
        MCLK = 1'b1;
        step(2);
        check("int16_pre_alive", ALIVE, 1);
        step(1);
        check("int16_period", PERIOD, 16);
        check("int16_alive",  ALIVE,  1);
        check("int16_lost",   LOST,   0);
        step(5);
        MCLK = 1'b0;
        step(9);
        MCLK = 1'b1;
        step(1);
        check("int17_pre_alive", ALIVE, 1);
        check("int17_pre_lost",  LOST,  0);
        step(1);
        check("int17_alive", ALIVE,  0);
        check("int17_lost",  LOST,   1);
        check("int17_lossp", LOSS_P, 1);
        step(1);
        check("int17_edge_lossp",  LOSS_P, 0);
        check("int17_edge_period", PERIOD, 16);
        check("int17_edge_alive",  ALIVE,  0);

        // CLR coincident with loss entry from ACQ: set wins
        CLR = 1'b1;
        step(1);
        CLR  = 1'b0;
        MCLK = 1'b0;
        check("acqclr_lost", LOST, 0);
        step(14);
        check("acq15_lost",  LOST,   0);
        check("acq15_lossp", LOSS_P, 0);
        CLR = 1'b1;
        step(1);
        check("clrcoin_lost",  LOST,   1);
        check("clrcoin_lossp", LOSS_P, 1);
        step(1);
        CLR = 1'b0;
        check("clrlater_lost", LOST, 0);

        // Reach RUN with LOST set, then asynchronous reset between edges
        repeat (4) pulse8();
        check("pre_rst_run_alive", ALIVE, 1);
        step(11);
        check("pre_rst_loss_lost", LOST, 1);
        repeat (4) pulse8();
        check("pre_rst_alive",  ALIVE,  1);
        check("pre_rst_lost",   LOST,   1);
        check("pre_rst_period", PERIOD, 8);
        step(1);
        #2 RST = 1'b1;
        #1;
        check("arst_alive",  ALIVE,  0);
        check("arst_lost",   LOST,   0);
        check("arst_lossp",  LOSS_P, 0);
        check("arst_period", PERIOD, 0);
        #1 RST = 1'b0;
        step(1);
        check("post_rst_alive", ALIVE, 0);
        pulse8();
        check("post_rst1_period", PERIOD, 0);
        pulse8();
        pulse8();
        check("post_rst3_alive", ALIVE, 0);
        MCLK = 1'b1;
        step(2);
        check("post_rst4_pre_alive", ALIVE, 0);
        step(1);
        check("post_rst4_alive",  ALIVE,  1);
        check("post_rst4_period", PERIOD, 8);
        check("post_rst4_lost",   LOST,   0);
        MCLK = 1'b0;
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clkloss_mon.md
# clkloss_mon

Clock-loss watchdog that complements the clock-presence detector cell. It runs on the system clock and treats a monitored clock as asynchronous data. It declares the monitored clock ALIVE after a run of timely edges, and declares LOST when no edge arrives within a timeout. It also reports the last measured period in system-clock cycles. It sits beside PLL/recovered-clock logic in the SC simulation library and feeds status/interrupt logic.

## Interface
- TIMEOUT, 16: number of CLK cycles with no monitored edge that declares loss; 2 ≤ TIMEOUT ≤ 2^CNTW−1.
- LOCKCNT, 4: number of consecutive timely monitored edges required to declare ALIVE; ≥ 1.
- CNTW, 8: width of the interval timer and of PERIOD.
- CLK, input, 1: system clock; all state changes on its rising edge.
- RST, input, 1: reset, asynchronous, active-high.
- MCLK, input, 1: monitored clock, asynchronous to CLK, sampled as data.
- CLR, input, 1: synchronous clear of the sticky LOST flag.
- ALIVE, output, 1: high while state is RUN.
- LOST, output, 1: sticky loss flag.
- LOSS_P, output, 1: one-cycle pulse on each entry to LOSS.
- PERIOD, output, CNTW: CLK cycles between the last two monitored rising edges.

## Operation
- Synchroniser: MCLK passes through S1 then S2, followed by S3 for edge detection. Edge event E = S2 & ~S3, which is a rising edge only.
- Timer T (CNTW bits):
  - cleared to 0 on any edge where E = 1;
  - otherwise increments, saturating at TIMEOUT.
- Edge counter N counts timely edges in ACQ.
- States and transitions:
  - WAIT (reset state): no timeout applies. E → ACQ with N = 1.
  - ACQ:
    - E with N+1 = LOCKCNT → RUN.
    - E otherwise → N = N+1.
    - No E and T = TIMEOUT−1 → LOSS.
  - RUN: no E and T = TIMEOUT−1 → LOSS.
  - LOSS: E → ACQ with N = 1. If LOCKCNT = 1, E goes directly to RUN from WAIT and LOSS.
- PERIOD update: PERIOD ← T+1 on every E taken in ACQ or RUN. It is not updated on E in WAIT or LOSS, because there is no valid reference edge. Valid PERIOD values range from 1 to TIMEOUT.
- Flags:
  - LOSS_P = 1 for exactly the cycle after each entry into LOSS; registered, asserted with state = LOSS.
  - LOST is set on entry to LOSS and stays set until CLR or RST. It remains set through re-acquisition.
  - CLR and a loss entry on the same edge: set wins, so LOST = 1.
- E coincident with the timeout condition: E wins and no loss occurs.
- Reset values, applied immediately on RST rise:
  - S1, S2, S3, T, N = 0;
  - state = WAIT;
  - ALIVE, LOST, LOSS_P = 0;
  - PERIOD = 0.
- RST mid-operation: everything returns to WAIT. A fresh run of LOCKCNT edges is needed before ALIVE.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- MCLK rise sampled by S1 at CLK edge n → S2 = 1 after edge n+1 → E acted on at edge n+2. Sync latency is 2 cycles plus up to 1 cycle of sampling uncertainty.
- ALIVE rises at the edge that acts on the LOCKCNT-th E.
- Loss is declared at the TIMEOUT-th CLK edge after the edge that acted on the last E:
  - interval of exactly TIMEOUT cycles → no loss;
  - interval of TIMEOUT+1 cycles → loss.
- ALIVE falls, LOST rises and LOSS_P pulses on the same edge.
- MCLK faster than CLK/2 aliases and is not guaranteed detected. The bench only uses MCLK high and low phases of at least 2 CLK cycles.

## Test plan
- Reset, then MCLK held 0 for 100 cycles → ALIVE = 0, LOST = 0, LOSS_P never pulses, PERIOD = 0 (WAIT has no timeout).
- MCLK period 8 CLK cycles (TIMEOUT = 16, LOCKCNT = 4) → ALIVE rises at the edge acting on the 4th E; PERIOD = 8 from the 2nd E onward; LOST stays 0.
- In RUN, stop MCLK → exactly 16 cycles after the last acted E: ALIVE = 0, LOST = 1, LOSS_P high for 1 cycle. Restart MCLK → ALIVE returns after 4 edges while LOST stays 1; CLR pulse → LOST = 0 next edge.
- Boundary: MCLK edge interval of 16 cycles → stays RUN with PERIOD = 16; change the interval to 17 → loss declared on the 16th cycle after the last E.
- CLR asserted on the same edge as loss entry → LOST = 1 after that edge; CLR one cycle later → LOST = 0.
- RST pulsed asynchronously mid-RUN, between CLK edges → ALIVE, LOST, LOSS_P and PERIOD go to 0 immediately; after release, 4 new edges are required before ALIVE = 1.
